gain_multi_channel: RTL and testbench
=====================================

# gain_multi_channel

Parametrised N-channel fixed-point gain stage for the FM radio datapath. It replaces single-channel gain with lock-stepped channels, such as L/R audio. Each channel has run-time programmable gain, round-toward-zero dequantization, and optional saturation with sticky overflow flags. The block sits between first-word-fall-through (show-ahead) input FIFOs and output FIFOs, and respects backpressure without losing samples.

## Interface
- NUM_CHANNELS, 2, number of lock-stepped channels (≥1)
- DATA_WIDTH, 32, signed sample width in and out
- GAIN_WIDTH, 32, signed gain width
- FRAC_BITS, 10, fractional bits of gain (unity = 1<<FRAC_BITS)
- SATURATE, 1, 1 = clamp to DATA_WIDTH signed range; 0 = two's-complement wrap (legacy)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- in_rd_en  out  1  pops all input FIFOs together
- in_empty  in  NUM_CHANNELS  per-channel input FIFO empty
- in_dout  in  NUM_CHANNELS×DATA_WIDTH  per-channel show-ahead data, signed
- out_wr_en  out  1  pushes all output FIFOs together
- out_full  in  NUM_CHANNELS  per-channel output FIFO full
- out_din  out  NUM_CHANNELS×DATA_WIDTH  per-channel result, signed
- cfg_wr_en  in  1  gain register write strobe
- cfg_chan  in  $clog2(NUM_CHANNELS) (min 1)  channel index for the write
- cfg_gain  in  GAIN_WIDTH  new gain, signed
- sat_clear  in  1  clears all sticky flags
- sat_flag  out  NUM_CHANNELS  sticky per-channel saturation/overflow flag

## Operation
- Per-channel gain register, reset to unity (1<<FRAC_BITS). Written on a cfg_wr_en cycle. cfg_chan ≥ NUM_CHANNELS is ignored.
- Two-stage pipeline, signals s1_valid and s2_valid:
  - Read (combinational): in_rd_en = ~|in_empty & adv. adv = ~s2_valid | ~|out_full.
  - S1: on in_rd_en, register product p[c] = in_dout[c] × gain[c] (full DATA+GAIN width, signed), and set s1_valid. Gain is sampled at the read cycle.
  - S2: when adv, load s2 from S1. Compute q = p >>> FRAC_BITS with round toward zero: if p < 0, add (1<<FRAC_BITS)−1 before the shift. Then:
    - SATURATE=1: clamp q to [−2^(DW−1), 2^(DW−1)−1].
    - SATURATE=0: take q[DW−1:0].
- Output: out_wr_en = s2_valid & ~|out_full. s2_valid clears on write unless S1 refills it the same cycle.
- Lock-step rule:
  - No channel is read unless all are non-empty.
  - No channel is written unless none is full.
  - Channel alignment is preserved.
- sat_flag[c] is set when q[c] lies outside the DATA_WIDTH range in either mode, computed in S2. sat_clear has priority over a same-cycle set.
- cfg write and read in the same cycle: the sample read uses the old gain. The new gain applies from the next read.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0, sat_flag=0, pipeline valids=0, gains=unity. Reset mid-stream discards in-flight samples. Input FIFOs are not popped during reset.
- Latency: read at cycle n gives out_wr_en at n+2, if no backpressure.
- Throughput: one sample per channel per cycle when sustained.
- out_full stall:
  - S2 holds its data and out_din is stable.
  - S1 holds if S2 is occupied.
  - Reads stop once both stages are full.
  - No loss and no duplication.
- out_full and in_empty can drop in the same cycle: the write and the read both occur.

## Structure
- Package gain_pkg holds:
  - the default constants (FRAC_BITS=10, unity gain);
  - a function dequantize(p, frac_bits) for round-toward-zero;
  - a function sat_clamp.
- Sub-module gain_lane holds one channel's gain register, multiply, dequantize, clamp and flag, with stall/advance inputs. It is generated NUM_CHANNELS times. The top level holds the shared valid/handshake logic.

## Test plan
- Unity gain, N=2: ch0 = 1000, −7; ch1 = 5, 0 → outputs identical. First out_wr_en two cycles after the first in_rd_en.
- Gain 2048 on ch0, 512 on ch1; inputs −3, −3 → −6 and −1 (round toward zero). Input 3 on ch1 → 1.
- Saturation, gain = 1<<20, input 2^30:
  - SATURATE=1 → 0x7FFFFFFF and sat_flag[0]=1.
  - Input −2^30 → 0x80000000.
  - sat_clear clears the flag.
  - SATURATE=0 → wrapped low 32 bits, flag still set.
- Backpressure: stream 200 random samples and hold out_full[1]=1 for 20 cycles mid-stream → no writes during the hold, output matches the C model in order, zero errors.
- Imbalance: ch1 FIFO empty while ch0 has 10 samples → in_rd_en stays 0. Fill ch1 → reads resume in aligned pairs.
- Reset mid-stream and gain update: change ch0 gain from 1024 to 3072 between samples k and k+1 → sample k+1 is tripled. Assert reset low with 2 samples in flight → outputs return to reset values, and no out_wr_en until a new read.

Source files
------------

// File: rtl/gain_pkg.sv
// Shared constants and fixed-point helpers for the multi-channel gain stage.
package gain_pkg;

    localparam int unsigned DEF_FRAC_BITS  = 10;
    localparam int unsigned DEF_UNITY_GAIN = 1 << DEF_FRAC_BITS;
    // Widest intermediate product; DATA_WIDTH + GAIN_WIDTH must not exceed it.
    localparam int unsigned ACC_W          = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Arithmetic shift that rounds toward zero instead of toward minus infinity.
    function automatic acc_t dequantize(input acc_t p, input int unsigned frac_bits);
        acc_t bias;
        bias = p[ACC_W-1] ? ((acc_t'(1) <<< frac_bits) - acc_t'(1)) : '0;
        return (p + bias) >>> frac_bits;
    endfunction

    function automatic logic out_of_range(input acc_t q, input int unsigned data_width);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (data_width - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (data_width - 1));
        return (q > hi) || (q < lo);
    endfunction

    function automatic acc_t sat_clamp(input acc_t q, input int unsigned data_width);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (data_width - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (data_width - 1));
        if (q > hi) begin
            return hi;
        end
        if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/gain_multi_channel_if.sv
// FIFO-side handshake and data for all lock-stepped channels.
interface gain_multi_channel_if #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_WIDTH   = 32
) ();

    logic                                   in_rd_en;
    logic [NUM_CHANNELS-1:0]                in_empty;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_dout;
    logic                                   out_wr_en;
    logic [NUM_CHANNELS-1:0]                out_full;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );

endinterface

// File: rtl/gain_lane.sv
// One channel: gain register, multiply, round-toward-zero dequantize, clamp or wrap, sticky flag.
module gain_lane
    import gain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GAIN_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter bit          SATURATE   = 1'b1,
    parameter int unsigned CHAN_W     = 1,
    parameter int unsigned LANE_IDX   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ld_s1,
    input  logic                  ld_s2,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  cfg_wr_en,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [GAIN_WIDTH-1:0] cfg_gain,
    input  logic                  sat_clear,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  sat_flag
);

    localparam int unsigned           PROD_W = DATA_WIDTH + GAIN_WIDTH;
    localparam logic [GAIN_WIDTH-1:0] UNITY  = GAIN_WIDTH'(1) << FRAC_BITS;

    logic [GAIN_WIDTH-1:0]    gain_q, gain_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic                     flag_q, flag_d;
    acc_t                     deq_c;
    acc_t                     res_c;
    logic                     ovf_c;

    always_comb begin
        gain_d = gain_q;
        prod_d = prod_q;
        dout_d = dout_q;
        flag_d = flag_q;

        if (cfg_wr_en && (cfg_chan == CHAN_W'(LANE_IDX))) begin
            gain_d = cfg_gain;
        end

        // Product uses the gain held before any same-cycle write.
        if (ld_s1) begin
            prod_d = PROD_W'($signed(din)) * PROD_W'($signed(gain_q));
        end

        deq_c = dequantize(ACC_W'(prod_q), FRAC_BITS);
        ovf_c = out_of_range(deq_c, DATA_WIDTH);
        res_c = SATURATE ? sat_clamp(deq_c, DATA_WIDTH) : deq_c;

        if (ld_s2) begin
            dout_d = DATA_WIDTH'(res_c);
            if (ovf_c) begin
                flag_d = 1'b1;
            end
        end

        if (sat_clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gain_q <= UNITY;
            prod_q <= '0;
            dout_q <= '0;
            flag_q <= 1'b0;
        end else begin
            gain_q <= gain_d;
            prod_q <= prod_d;
            dout_q <= dout_d;
            flag_q <= flag_d;
        end
    end

    assign dout     = dout_q;
    assign sat_flag = flag_q;

endmodule

// File: rtl/gain_multi_channel.sv
// N-channel lock-stepped gain stage between show-ahead input FIFOs and output FIFOs.
module gain_multi_channel
    import gain_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned GAIN_WIDTH   = 32,
    parameter int unsigned FRAC_BITS    = DEF_FRAC_BITS,
    parameter bit          SATURATE     = 1'b1,
    localparam int unsigned CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    gain_multi_channel_if.master    fifo,
    input  logic                    cfg_wr_en,
    input  logic [CHAN_W-1:0]       cfg_chan,
    input  logic [GAIN_WIDTH-1:0]   cfg_gain,
    input  logic                    sat_clear,
    output logic [NUM_CHANNELS-1:0] sat_flag
);

    logic run_q, run_d;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic adv_c, rd_c, wr_c, ld_s2_c;

    // Shared handshake: all channels read together, all written together.
    always_comb begin
        run_d      = 1'b1;
        adv_c      = ~s2_valid_q | ~|fifo.out_full;
        rd_c       = run_q & ~|fifo.in_empty & adv_c;
        wr_c       = s2_valid_q & ~|fifo.out_full;
        ld_s2_c    = adv_c & s1_valid_q;
        s1_valid_d = rd_c | (s1_valid_q & ~adv_c);
        s2_valid_d = adv_c ? s1_valid_q : s2_valid_q;
    end

    // run_q keeps the input FIFOs untouched until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign fifo.in_rd_en  = rd_c;
    assign fifo.out_wr_en = wr_c;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        gain_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .GAIN_WIDTH (GAIN_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .SATURATE   (SATURATE),
            .CHAN_W     (CHAN_W),
            .LANE_IDX   (c)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .ld_s1     (rd_c),
            .ld_s2     (ld_s2_c),
            .din       (fifo.in_dout[c]),
            .cfg_wr_en (cfg_wr_en),
            .cfg_chan  (cfg_chan),
            .cfg_gain  (cfg_gain),
            .sat_clear (sat_clear),
            .dout      (fifo.out_din[c]),
            .sat_flag  (sat_flag[c])
        );
    end

endmodule

// File: tb/tb_gain_multi_channel.sv
// Directed bench for gain_multi_channel: saturating and wrapping instances fed identical stimulus.
module tb_gain_multi_channel;
    import gain_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned GW  = 32;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    cfg_wr_en;
    logic [0:0]              cfg_chan;
    logic [GW-1:0]           cfg_gain;
    logic                    sat_clear;
    logic [NCH-1:0]          sat_flag_s, sat_flag_w;
    logic [NCH-1:0]          in_empty, out_full;
    logic [NCH-1:0][DW-1:0]  in_dout;

    gain_multi_channel_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus_s ();
    gain_multi_channel_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus_w ();

    assign bus_s.in_empty = in_empty;
    assign bus_s.in_dout  = in_dout;
    assign bus_s.out_full = out_full;
    assign bus_w.in_empty = in_empty;
    assign bus_w.in_dout  = in_dout;
    assign bus_w.out_full = out_full;

    gain_multi_channel #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .GAIN_WIDTH(GW),
                         .FRAC_BITS(DEF_FRAC_BITS), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset), .fifo(bus_s), .cfg_wr_en(cfg_wr_en), .cfg_chan(cfg_chan),
        .cfg_gain(cfg_gain), .sat_clear(sat_clear), .sat_flag(sat_flag_s));

    gain_multi_channel #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .GAIN_WIDTH(GW),
                         .FRAC_BITS(DEF_FRAC_BITS), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .fifo(bus_w), .cfg_wr_en(cfg_wr_en), .cfg_chan(cfg_chan),
        .cfg_gain(cfg_gain), .sat_clear(sat_clear), .sat_flag(sat_flag_w));

    always #5 clock = ~clock;

    int n_tests;
    int n_fail;
    int cyc;
    int first_rd;
    int first_wr;
    logic [31:0]      fq0[$];
    logic [31:0]      fq1[$];
    logic [1:0][31:0] sb_s[$];
    logic [1:0][31:0] sb_w[$];
    logic [31:0]      mgain[NCH];
    logic [NCH-1:0]   mflag;
    logic [1:0][31:0] hold_din;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, C-style truncating division, then clamp or wrap.
    function automatic void model(input logic [31:0] din, input logic [31:0] g,
                                  output logic [31:0] rs, output logic [31:0] rw, output logic ovf);
        longint p;
        longint q;
        p   = longint'($signed(din)) * longint'($signed(g));
        q   = p / longint'(DEF_UNITY_GAIN);
        ovf = (q > longint'(32'h7FFFFFFF)) || (q < -longint'(32'h80000000));
        rs  = ovf ? ((q > 0) ? 32'h7FFFFFFF : 32'h80000000) : q[31:0];
        rw  = q[31:0];
    endfunction

    task automatic drive_fifo();
        in_empty[0] = (fq0.size() == 0);
        in_empty[1] = (fq1.size() == 0);
        in_dout[0]  = in_empty[0] ? '0 : fq0[0];
        in_dout[1]  = in_empty[1] ? '0 : fq1[0];
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        fq0.push_back(a);
        fq1.push_back(b);
        drive_fifo();
    endtask

    // One clock: sample handshake mid-cycle, then apply its effects to the models after the edge.
    task automatic cycle();
        logic rd, wr_s, wr_w, o0, o1;
        logic [31:0] s0, s1, w0, w1;
        logic [1:0][31:0] ds, dw, e;
        @(negedge clock);
        rd   = bus_s.in_rd_en;
        wr_s = bus_s.out_wr_en;
        wr_w = bus_w.out_wr_en;
        ds   = bus_s.out_din;
        dw   = bus_w.out_din;
        @(posedge clock);
        #1;
        cyc++;
        if (rd) begin
            if (first_rd < 0) first_rd = cyc;
            check("rd_both_nonempty", 64'(fq0.size() != 0 && fq1.size() != 0), 64'(1));
            if (fq0.size() != 0 && fq1.size() != 0) begin
                model(fq0[0], mgain[0], s0, w0, o0);
                model(fq1[0], mgain[1], s1, w1, o1);
                mflag = mflag | {o1, o0};
                sb_s.push_back({s1, s0});
                sb_w.push_back({w1, w0});
                void'(fq0.pop_front());
                void'(fq1.pop_front());
            end
        end
        if (cfg_wr_en && reset) mgain[cfg_chan] = cfg_gain;
        if (wr_s) begin
            if (first_wr < 0) first_wr = cyc;
            check("wr_sat_has_expect", 64'(sb_s.size() != 0), 64'(1));
            if (sb_s.size() != 0) begin
                e = sb_s.pop_front();
                check("ch0_sat", 64'(ds[0]), 64'(e[0]));
                check("ch1_sat", 64'(ds[1]), 64'(e[1]));
            end
        end
        if (wr_w) begin
            check("wr_wrap_has_expect", 64'(sb_w.size() != 0), 64'(1));
            if (sb_w.size() != 0) begin
                e = sb_w.pop_front();
                check("ch0_wrap", 64'(dw[0]), 64'(e[0]));
                check("ch1_wrap", 64'(dw[1]), 64'(e[1]));
            end
        end
        drive_fifo();
    endtask

    task automatic cfg(input int chan, input logic [31:0] g);
        cfg_wr_en = 1'b1;
        cfg_chan  = 1'(chan);
        cfg_gain  = g;
        cycle();
        cfg_wr_en = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((fq0.size() != 0 || fq1.size() != 0 || sb_s.size() != 0 || sb_w.size() != 0)
               && budget < 1000) begin
            cycle();
            budget++;
        end
        check("drain_sat", 64'(sb_s.size()), 64'(0));
        check("drain_wrap", 64'(sb_w.size()), 64'(0));
        check("flag_sat", 64'(sat_flag_s), 64'(mflag));
        check("flag_wrap", 64'(sat_flag_w), 64'(mflag));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, 64'({bus_s.in_rd_en, bus_w.in_rd_en}), 64'(0));
        check({tag, "_wr"}, 64'({bus_s.out_wr_en, bus_w.out_wr_en}), 64'(0));
        check({tag, "_din_sat"}, 64'(bus_s.out_din), 64'(0));
        check({tag, "_din_wrap"}, 64'(bus_w.out_din), 64'(0));
        check({tag, "_flags"}, 64'({sat_flag_s, sat_flag_w}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; first_rd = -1; first_wr = -1;
        reset = 1'b0; cfg_wr_en = 1'b0; cfg_chan = '0; cfg_gain = '0; sat_clear = 1'b0;
        out_full = '0; mflag = '0;
        for (int i = 0; i < NCH; i++) mgain[i] = DEF_UNITY_GAIN;
        drive_fifo();

        // Reset with data waiting: nothing may be popped.
        push_pair(32'd1000, 32'd5);
        push_pair(-32'sd7, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Unity gain pass-through and two-cycle latency.
        drain();
        check("latency", 64'(first_wr - first_rd), 64'(2));

        // Round toward zero on negative products.
        cfg(0, 32'd2048);
        cfg(1, 32'd512);
        push_pair(-32'sd3, -32'sd3);
        push_pair(32'd0, 32'd3);
        drain();

        // Saturation versus wrap, then sticky flag clear.
        cfg(0, 32'h0010_0000);
        cfg(1, 32'd1024);
        push_pair(32'h4000_0000, 32'd1);
        push_pair(32'hC000_0000, -32'sd1);
        drain();
        sat_clear = 1'b1;
        cycle();
        sat_clear = 1'b0;
        mflag = '0;
        check("flag_cleared", 64'({sat_flag_s, sat_flag_w}), 64'(0));

        // Clear asserted on the very edge an overflowing sample enters the output stage.
        push_pair(32'h4000_0000, 32'd2);
        cycle();
        sat_clear = 1'b1;
        cycle();
        sat_clear = 1'b0;
        mflag = '0;
        drain();

        // Gain update between samples, and a write coinciding with a read.
        cfg(0, 32'd1024);
        push_pair(32'd100, 32'd100);
        cycle();
        cfg(0, 32'd3072);
        push_pair(32'd100, 32'd100);
        drain();
        push_pair(32'd50, 32'd50);
        cfg(0, 32'd1024);
        push_pair(32'd50, 32'd50);
        drain();

        // Random stream with a 20-cycle stall on channel 1's output FIFO.
        cfg(0, 32'($urandom_range(8192)) - 32'd4096);
        cfg(1, 32'($urandom_range(8192)) - 32'd4096);
        for (int i = 0; i < 200; i++) push_pair($urandom, $urandom);
        for (int i = 0; i < 40; i++) cycle();
        out_full = 2'b10;
        hold_din = bus_s.out_din;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("hold_no_wr", 64'(bus_s.out_wr_en), 64'(0));
            check("hold_din_stable", 64'(bus_s.out_din), 64'(hold_din));
        end
        check("hold_no_rd", 64'(bus_s.in_rd_en), 64'(0));
        out_full = '0;
        drain();

        // Channel imbalance blocks reads until both FIFOs have data.
        sat_clear = 1'b1;
        cycle();
        sat_clear = 1'b0;
        mflag = '0;
        cfg(0, 32'd1024);
        cfg(1, 32'd2048);
        for (int i = 0; i < 10; i++) fq0.push_back(32'(i * 11));
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("imbalance_no_rd", 64'(bus_s.in_rd_en), 64'(0));
        end
        for (int i = 0; i < 10; i++) fq1.push_back(32'(i + 1));
        drive_fifo();
        drain();

        // Reset mid-stream discards in-flight samples and restores unity gain.
        cfg(0, 32'd3072);
        for (int i = 0; i < 4; i++) push_pair(32'(i + 20), 32'(i + 40));
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_s.delete(); sb_w.delete(); fq0.delete(); fq1.delete();
        mflag = '0;
        for (int i = 0; i < NCH; i++) mgain[i] = DEF_UNITY_GAIN;
        drive_fifo();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("post_reset_no_wr", 64'(bus_s.out_wr_en), 64'(0));
        end
        push_pair(32'd7, -32'sd7);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
